// File: rtl/control_types.sv
// Shared control encodings for the core: memory access size/sign and the
// data-memory arbiter state.
package control_types;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_op_t;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t NORMAL     = 1'b0;
  localparam arb_state_t DBG_LOCKED = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields plus the
// grant and registered read response returned by the arbiter.
interface dmem_arbiter_if;
  import control_types::*;

  logic        req;
  logic        we;
  mem_op_t     op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output we, output op, output addr, output wdata,
                  input gnt, input rvalid, input rdata);

  modport slave (input req, input we, input op, input addr, input wdata,
                 output gnt, output rvalid, output rdata);

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-port read response stage: one-cycle rvalid pulse after a granted read,
// rdata held until the next read response on the same port.
module dmem_rsp_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] data_in,
  output logic        rvalid,
  output logic [31:0] rdata
);

  logic        rvalid_r;
  logic [31:0] rdata_r;

  // capture the combinational memory read on the grant edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      rvalid_r <= capture;
      if (capture) begin
        rdata_r <= data_in;
      end
    end
  end

  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory between the CPU MEM-stage port and the
// debug/loader port. CPU has priority; debug gets bounded wait and a lock.
module dmem_arbiter
  import control_types::*;
#(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave cpu,
  dmem_arbiter_if.slave dbg,
  input  logic          dbg_lock,
  output logic          mem_wr_en,
  output mem_op_t       mem_op,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_data_in,
  input  logic [31:0]   mem_data_out
);

  localparam int WCW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

  arb_state_t     state_r;
  arb_state_t     state_nxt_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [WCW-1:0] wait_cnt_nxt_s;
  logic           locked_s;
  logic           cpu_gnt_s;
  logic           dbg_gnt_s;

  // dropping dbg_lock releases the CPU in the same cycle
  assign locked_s = (state_r == DBG_LOCKED) && dbg_lock;

  // grant selection: lock owner, else CPU priority unless debug has waited out
  always_comb begin
    cpu_gnt_s = 1'b0;
    dbg_gnt_s = 1'b0;
    if (locked_s) begin
      dbg_gnt_s = dbg.req;
    end else if (cpu.req && dbg.req) begin
      if (wait_cnt_r == WAIT_MAX) begin
        dbg_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b1;
      end
    end else begin
      cpu_gnt_s = cpu.req;
      dbg_gnt_s = dbg.req;
    end
  end

  // next state and starvation counter
  always_comb begin
    state_nxt_s    = NORMAL;
    wait_cnt_nxt_s = {WCW{1'b0}};
    if (dbg_lock && (locked_s || dbg_gnt_s)) begin
      state_nxt_s = DBG_LOCKED;
    end else begin
      state_nxt_s = NORMAL;
    end
    if (dbg.req && !dbg_gnt_s) begin
      if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
      end else begin
        wait_cnt_nxt_s = wait_cnt_r;
      end
    end else begin
      wait_cnt_nxt_s = {WCW{1'b0}};
    end
  end

  // arbiter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= NORMAL;
      wait_cnt_r <= {WCW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // memory mux; CPU fields are forwarded when nobody is granted
  always_comb begin
    mem_op      = cpu.op;
    mem_addr    = cpu.addr;
    mem_data_in = cpu.wdata;
    if (dbg_gnt_s) begin
      mem_op      = dbg.op;
      mem_addr    = dbg.addr;
      mem_data_in = dbg.wdata;
    end else begin
      mem_op      = cpu.op;
      mem_addr    = cpu.addr;
      mem_data_in = cpu.wdata;
    end
  end

  assign mem_wr_en = (cpu_gnt_s && cpu.we) || (dbg_gnt_s && dbg.we);
  assign cpu.gnt   = cpu_gnt_s;
  assign dbg.gnt   = dbg_gnt_s;

  dmem_rsp_reg u_cpu_rsp (
    .clk     (clk),
    .reset   (reset),
    .capture (cpu_gnt_s && !cpu.we),
    .data_in (mem_data_out),
    .rvalid  (cpu.rvalid),
    .rdata   (cpu.rdata)
  );

  dmem_rsp_reg u_dbg_rsp (
    .clk     (clk),
    .reset   (reset),
    .capture (dbg_gnt_s && !dbg.we),
    .data_in (mem_data_out),
    .rvalid  (dbg.rvalid),
    .rdata   (dbg.rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A (DBG_MAX_WAIT=4) on a word
// memory model, instance B (DBG_MAX_WAIT=0) on an address-derived read pattern.
module tb_dmem_arbiter;
  import control_types::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_lock_a = 1'b0;
  logic dbg_lock_b = 1'b0;

  dmem_arbiter_if cpu_a ();
  dmem_arbiter_if dbg_a ();
  dmem_arbiter_if cpu_b ();
  dmem_arbiter_if dbg_b ();

  logic        mem_wr_en_a, mem_wr_en_b;
  mem_op_t     mem_op_a, mem_op_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_data_in_a, mem_data_in_b;
  logic [31:0] mem_data_out_a, mem_data_out_b;

  logic [31:0] mem_a [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DBG_MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(reset), .cpu(cpu_a), .dbg(dbg_a), .dbg_lock(dbg_lock_a),
    .mem_wr_en(mem_wr_en_a), .mem_op(mem_op_a), .mem_addr(mem_addr_a),
    .mem_data_in(mem_data_in_a), .mem_data_out(mem_data_out_a)
  );

  dmem_arbiter #(.DBG_MAX_WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .cpu(cpu_b), .dbg(dbg_b), .dbg_lock(dbg_lock_b),
    .mem_wr_en(mem_wr_en_b), .mem_op(mem_op_b), .mem_addr(mem_addr_b),
    .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b)
  );

  // word-addressed data memory: combinational read, write at the rising edge
  always @(posedge clk) begin
    if (mem_wr_en_a) mem_a[mem_addr_a[9:2]] <= mem_data_in_a;
  end
  assign mem_data_out_a = mem_a[mem_addr_a[9:2]];
  assign mem_data_out_b = mem_addr_b ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drv(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_a.req = req; cpu_a.we = we; cpu_a.op = MEM_WORD;
    cpu_a.addr = addr; cpu_a.wdata = wdata;
  endtask

  task automatic dbg_drv(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
    dbg_a.req = req; dbg_a.we = we; dbg_a.op = MEM_WORD;
    dbg_a.addr = addr; dbg_a.wdata = wdata; dbg_lock_a = lock;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cpu_b.req = 1'b0; cpu_b.we = 1'b0; cpu_b.op = MEM_WORD; cpu_b.addr = 32'd0; cpu_b.wdata = 32'd0;
    dbg_b.req = 1'b0; dbg_b.we = 1'b0; dbg_b.op = MEM_WORD; dbg_b.addr = 32'd0; dbg_b.wdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_cpu_gnt", 32'(cpu_a.gnt), 32'd0);
    check("rst_dbg_gnt", 32'(dbg_a.gnt), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en_a), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_a.rvalid), 32'd0);
    check("rst_dbg_rvalid", 32'(dbg_a.rvalid), 32'd0);
    check("rst_cpu_rdata", cpu_a.rdata, 32'd0);
    check("rst_dbg_rdata", dbg_a.rdata, 32'd0);

    // CPU-only write then read of 0x40
    cpu_drv(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    #1;
    check("cpu_wr_gnt", 32'(cpu_a.gnt), 32'd1);
    check("cpu_wr_en", 32'(mem_wr_en_a), 32'd1);
    check("cpu_wr_addr", mem_addr_a, 32'h40);
    check("cpu_wr_op", {29'd0, mem_op_a}, {29'd0, MEM_WORD});
    check("cpu_wr_data", mem_data_in_a, 32'hDEADBEEF);
    tick();
    check("cpu_wr_no_rvalid", 32'(cpu_a.rvalid), 32'd0);
    cpu_drv(1'b1, 1'b0, 32'h40, 32'd0);
    #1;
    check("cpu_rd_gnt", 32'(cpu_a.gnt), 32'd1);
    check("cpu_rd_wr_en", 32'(mem_wr_en_a), 32'd0);
    tick();
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    check("cpu_rd_rvalid", 32'(cpu_a.rvalid), 32'd1);
    check("cpu_rd_rdata", cpu_a.rdata, 32'hDEADBEEF);
    tick();
    check("cpu_rvalid_pulse", 32'(cpu_a.rvalid), 32'd0);
    check("cpu_rdata_hold", cpu_a.rdata, 32'hDEADBEEF);

    // continuous conflict: debug wins only when it has waited 4 cycles
    cpu_drv(1'b1, 1'b0, 32'h40, 32'd0);
    dbg_drv(1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("conf_cpu_gnt_%0d", c), 32'(cpu_a.gnt), 32'(c != 4));
      check($sformatf("conf_dbg_gnt_%0d", c), 32'(dbg_a.gnt), 32'(c == 4));
      tick();
      check($sformatf("conf_cpu_rv_%0d", c), 32'(cpu_a.rvalid), 32'(c != 4));
      check($sformatf("conf_dbg_rv_%0d", c), 32'(dbg_a.rvalid), 32'(c == 4));
    end
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    // locked debug burst while the CPU waits
    dbg_drv(1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1);
    #1;
    check("lock_b0_gnt", 32'(dbg_a.gnt), 32'd1);
    check("lock_b0_addr", mem_addr_a, 32'h100);
    tick();
    cpu_drv(1'b1, 1'b0, 32'h104, 32'd0);
    dbg_drv(1'b1, 1'b1, 32'h104, 32'h2222_2222, 1'b1);
    #1;
    check("lock_b1_cpu_gnt", 32'(cpu_a.gnt), 32'd0);
    check("lock_b1_dbg_gnt", 32'(dbg_a.gnt), 32'd1);
    check("lock_b1_wdata", mem_data_in_a, 32'h2222_2222);
    tick();
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    #1;
    check("lock_idle_cpu_gnt", 32'(cpu_a.gnt), 32'd0);
    check("lock_idle_wr_en", 32'(mem_wr_en_a), 32'd0);
    check("lock_wr_no_rvalid", 32'(dbg_a.rvalid), 32'd0);
    tick();
    dbg_drv(1'b1, 1'b1, 32'h108, 32'h3333_3333, 1'b1);
    #1;
    check("lock_b2_cpu_gnt", 32'(cpu_a.gnt), 32'd0);
    check("lock_b2_dbg_gnt", 32'(dbg_a.gnt), 32'd1);
    tick();
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("unlock_cpu_gnt", 32'(cpu_a.gnt), 32'd1);
    check("unlock_addr", mem_addr_a, 32'h104);
    tick();
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    check("unlock_rdata", cpu_a.rdata, 32'h2222_2222);

    // simultaneous reads: CPU first, debug next cycle
    cpu_drv(1'b1, 1'b0, 32'h100, 32'd0);
    dbg_drv(1'b1, 1'b0, 32'h108, 32'd0, 1'b0);
    #1;
    check("sim_cpu_gnt", 32'(cpu_a.gnt), 32'd1);
    check("sim_dbg_gnt", 32'(dbg_a.gnt), 32'd0);
    tick();
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    check("sim_cpu_rdata", cpu_a.rdata, 32'h1111_1111);
    check("sim_dbg_rv0", 32'(dbg_a.rvalid), 32'd0);
    #1;
    check("sim_dbg_gnt2", 32'(dbg_a.gnt), 32'd1);
    tick();
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("sim_dbg_rv1", 32'(dbg_a.rvalid), 32'd1);
    check("sim_dbg_rdata", dbg_a.rdata, 32'h3333_3333);
    check("sim_cpu_rdata_keep", cpu_a.rdata, 32'h1111_1111);

    // reset while a CPU read response is pending
    cpu_drv(1'b1, 1'b0, 32'h40, 32'd0);
    #1;
    check("rstrd_gnt", 32'(cpu_a.gnt), 32'd1);
    tick();
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    check("rstrd_rv_before", 32'(cpu_a.rvalid), 32'd1);
    reset = 1'b1;
    tick();
    check("rstrd_rvalid", 32'(cpu_a.rvalid), 32'd0);
    check("rstrd_rdata", cpu_a.rdata, 32'd0);
    check("rstrd_dbg_rdata", dbg_a.rdata, 32'd0);
    reset = 1'b0;

    // reset while locked returns to NORMAL; lock alone then has no effect
    dbg_drv(1'b1, 1'b1, 32'h10C, 32'h4444_4444, 1'b1);
    #1;
    check("rstlk_dbg_gnt", 32'(dbg_a.gnt), 32'd1);
    tick();
    dbg_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_drv(1'b1, 1'b0, 32'h10C, 32'd0);
    #1;
    check("rstlk_cpu_gnt", 32'(cpu_a.gnt), 32'd1);
    tick();
    cpu_drv(1'b0, 1'b0, 32'd0, 32'd0);
    dbg_lock_a = 1'b0;
    check("rstlk_rdata", cpu_a.rdata, 32'h4444_4444);

    // DBG_MAX_WAIT = 0: debug wins every conflict
    cpu_b.req = 1'b1; cpu_b.we = 1'b0; cpu_b.op = MEM_WORD; cpu_b.addr = 32'h20;
    dbg_b.req = 1'b1; dbg_b.we = 1'b1; dbg_b.op = MEM_HALF; dbg_b.addr = 32'h30;
    dbg_b.wdata = 32'h5A5A_5A5A;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("w0_dbg_gnt_%0d", c), 32'(dbg_b.gnt), 32'd1);
      check($sformatf("w0_cpu_gnt_%0d", c), 32'(cpu_b.gnt), 32'd0);
      check($sformatf("w0_wr_en_%0d", c), 32'(mem_wr_en_b), 32'd1);
      tick();
    end
    check("w0_addr", mem_addr_b, 32'h30);
    check("w0_wdata", mem_data_in_b, 32'h5A5A_5A5A);
    check("w0_op", {29'd0, mem_op_b}, {29'd0, MEM_HALF});
    dbg_b.we = 1'b0; dbg_b.addr = 32'h34;
    #1;
    check("w0_rd_dbg_gnt", 32'(dbg_b.gnt), 32'd1);
    check("w0_rd_cpu_gnt", 32'(cpu_b.gnt), 32'd0);
    tick();
    dbg_b.req = 1'b0;
    check("w0_dbg_rvalid", 32'(dbg_b.rvalid), 32'd1);
    check("w0_dbg_rdata", dbg_b.rdata, 32'hA5A5_0034);
    #1;
    check("w0_cpu_alone_gnt", 32'(cpu_b.gnt), 32'd1);
    tick();
    cpu_b.req = 1'b0;
    check("w0_cpu_rvalid", 32'(cpu_b.rvalid), 32'd1);
    check("w0_cpu_rdata", cpu_b.rdata, 32'hA5A5_0020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single `data_memory` instance between the CPU's MEM-stage data port and a debug/loader port. CPU has fixed priority; debug is protected from starvation by a bounded wait counter and can lock the memory for multi-beat transfers (program/data load with the core stalled). Sits between `cpu` and `data_memory` in the top-level and in every instruction testbench.

## Interface
- `DBG_MAX_WAIT`, default 4: cycles a blocked debug request waits before it overrides the CPU; 0 means debug always wins a conflict.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `cpu_req` input 1: CPU access request, held until `cpu_gnt`.
- `cpu_we` input 1: CPU write enable.
- `cpu_op` input `mem_op_t`: CPU access size/sign.
- `cpu_addr` input 32: CPU byte address.
- `cpu_wdata` input 32: CPU write data.
- `cpu_gnt` output 1: CPU access performed this cycle. Low with `cpu_req` high means stall.
- `cpu_rvalid` output 1: CPU read data valid, one cycle after a granted read.
- `cpu_rdata` output 32: CPU read data.
- `dbg_req`, `dbg_we`, `dbg_op`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meaning and widths for the debug port.
- `dbg_lock` input 1: while high after a debug grant, debug keeps exclusive ownership.
- `mem_wr_en` output 1: to `data_memory.wr_en`.
- `mem_op` output `mem_op_t`: to `data_memory.mem_ctrl`.
- `mem_addr` output 32: to `data_memory.addr`.
- `mem_data_in` output 32: to `data_memory.data_in`.
- `mem_data_out` input 32: from `data_memory.data_out`. Combinational read.

## Operation
- FSM states:
  - `NORMAL`: arbitrate every cycle.
  - `DBG_LOCKED`: CPU blocked.
- `NORMAL` to `DBG_LOCKED` on a cycle with `dbg_gnt && dbg_lock`.
- `DBG_LOCKED` to `NORMAL` on any cycle with `dbg_lock` = 0. That cycle is still arbitrated as `NORMAL`, so the unlock is effective immediately.
- Grant in `NORMAL`:
  - Only one request: grant it.
  - Both requests: grant CPU, unless `wait_cnt == DBG_MAX_WAIT`, then grant debug.
- Grant in `DBG_LOCKED` (with `dbg_lock` still high): `dbg_gnt = dbg_req`, `cpu_gnt` = 0.
- `wait_cnt`:
  - Width `$clog2(DBG_MAX_WAIT+1)`, minimum 1.
  - Increments, saturating at `DBG_MAX_WAIT`, each cycle `dbg_req && !dbg_gnt`.
  - Clears on `dbg_gnt` or `!dbg_req`.
- Memory mux:
  - Forwards the granted port's op/addr/wdata.
  - `mem_wr_en = gnt && we` of the granted port.
  - With no grant, it forwards the CPU fields and `mem_wr_en` = 0.
- Read response: on a granted read (`we` = 0), `mem_data_out` is registered into that port's `rdata`, and its `rvalid` pulses high for exactly one cycle. `rdata` holds its value until the next read response on that port.
- Writes produce no `rvalid`.

## Timing
- Grants are combinational from the requests plus registered state. The memory access happens in the grant cycle, and the write commits at that rising edge.
- Read latency: `rvalid`/`rdata` appear 1 cycle after `gnt`.
- Back-to-back grants to the same or alternating ports every cycle are legal. Throughput is 1 access per cycle.
- Reset values:
  - `cpu_gnt`, `dbg_gnt`, `mem_wr_en`: 0 (with no requests).
  - `cpu_rvalid`, `dbg_rvalid`: 0.
  - `cpu_rdata`, `dbg_rdata`: 0.
  - `wait_cnt`: 0; state: `NORMAL`.
- Reset while a read is pending: its `rvalid` is dropped (0 in the cycle after reset). Reset while locked: returns to `NORMAL`.
- `dbg_lock` high without `dbg_req`: no effect in `NORMAL`. In `DBG_LOCKED` it keeps the CPU blocked.
- Requester rule: fields must stay stable while `req` is high and `gnt` is low. The arbiter does not latch them.

## Structure
- `mem_op_t` comes from the existing `control_types` package.
- Add `arb_state_t` (`NORMAL`, `DBG_LOCKED`) to the same package.
- One natural sub-module: `dmem_rsp_reg`, the per-port registered read-response stage (`rvalid` pulse plus `rdata` hold), instantiated twice.
- `cpu` uses `cpu_gnt` to hold its MEM stage.

## Test plan
- CPU only: write 32'hDEADBEEF to 0x40, then read 0x40. Expect `cpu_gnt` = 1 both cycles, `cpu_rvalid` one cycle after the read, `cpu_rdata` = 32'hDEADBEEF.
- Conflict with `DBG_MAX_WAIT`=4: `cpu_req` and `dbg_req` held high continuously. Expect CPU granted for cycles 0–3 and debug granted on cycle 4 (`wait_cnt` = 4). CPU `gnt` is low that cycle, then `wait_cnt` returns to 0.
- Debug lock:
  - Debug writes 0x100, 0x104, 0x108 with `dbg_lock` = 1 while `cpu_req` = 1. Expect `cpu_gnt` = 0 throughout.
  - Then drop `dbg_lock`. Expect `cpu_gnt` = 1 in that same cycle.
  - Then a CPU read of 0x104 returns the debug data.
- Simultaneous reads to different addresses: CPU wins. `dbg_rvalid` stays 0 until debug is granted, and `cpu_rdata` is unaffected by the later debug read.
- Reset mid-read: assert `reset` in the cycle after a granted CPU read. Expect `cpu_rvalid` = 0, `cpu_rdata` = 0, state `NORMAL`.
- `DBG_MAX_WAIT`=0: both ports request. Expect debug granted immediately every conflict cycle.
